dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates CPU load/store pulses and a held IO request onto one synchronous-read data memory.
// Latency: request sampled in IDLE at edge T, memory driven at T+1 (ACC), finish/ack and load data at T+2 (FIN).
// Backpressure: none to the CPU; one-deep pending slot, overflow drops the pulse and sets sticky cpu_ovf; IO holds io_req.
module dmem_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_l_valid,
    input  logic        cpu_s_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_load_finish,
    output logic        cpu_store_finish,
    output logic [31:0] cpu_rdata,
    input  logic        io_req,
    input  logic        io_we,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic        io_ack,
    output logic [31:0] io_rdata,
    output logic [31:0] d_addr,
    output logic [31:0] d_din,
    output logic        wea,
    input  logic [31:0] d_dout,
    output logic        cpu_ovf
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic          pend_vld_q, pend_vld_d;
    logic          pend_we_q, pend_we_d;
    logic [31:0]   pend_addr_q, pend_addr_d;
    logic [31:0]   pend_wdata_q, pend_wdata_d;

    logic          own_io_q, own_io_d;
    logic          op_we_q, op_we_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ovf_q, ovf_d;

    logic [31:0]   d_addr_q, d_addr_d;
    logic [31:0]   d_din_q, d_din_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   io_rdata_q, io_rdata_d;

    logic          live_vld;
    logic          live_dual;
    logic          idle;
    logic          cpu_cand;
    logic          cand_we;
    logic [31:0]   cand_addr;
    logic [31:0]   cand_wdata;
    logic          io_force;
    logic          grant_io;
    logic          grant_cpu;
    logic          grant_any;
    logic          grant_pend;
    logic          live_park;
    logic          slot_free;

    // The pending slot is older than a live pulse, so it is the CPU candidate whenever it is full.
    always_comb begin
        live_vld   = cpu_l_valid | cpu_s_valid;
        live_dual  = cpu_l_valid & cpu_s_valid;
        idle       = (state_q == IDLE);
        cpu_cand   = pend_vld_q | live_vld;
        cand_we    = pend_vld_q ? pend_we_q    : cpu_s_valid;
        cand_addr  = pend_vld_q ? pend_addr_q  : cpu_addr;
        cand_wdata = pend_vld_q ? pend_wdata_q : cpu_wdata;
        io_force   = io_req & (starve_q == STARVE_LIM);
        grant_io   = idle & io_req & (~cpu_cand | io_force);
        grant_cpu  = idle & cpu_cand & ~grant_io;
        grant_any  = grant_io | grant_cpu;
        grant_pend = grant_cpu & pend_vld_q;
        live_park  = live_vld & ~(grant_cpu & ~pend_vld_q);
        slot_free  = ~pend_vld_q | grant_pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_any) state_d = ACC;
            ACC:     state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wea              = (state_q == ACC) & op_we_q;
        cpu_load_finish  = (state_q == FIN) & ~own_io_q & ~op_we_q;
        cpu_store_finish = (state_q == FIN) & ~own_io_q &  op_we_q;
        io_ack           = (state_q == FIN) &  own_io_q;
        // Load data is forwarded straight from memory in FIN, then held by the capture register.
        cpu_rdata        = cpu_load_finish ? d_dout : cpu_rdata_q;
        io_rdata         = (io_ack & ~op_we_q) ? d_dout : io_rdata_q;
        d_addr           = d_addr_q;
        d_din            = d_din_q;
        cpu_ovf          = ovf_q;
    end

    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        if (grant_pend) begin
            pend_vld_d = 1'b0;
        end
        if (live_park && slot_free) begin
            pend_vld_d   = 1'b1;
            pend_we_d    = cpu_s_valid;
            pend_addr_d  = cpu_addr;
            pend_wdata_d = cpu_wdata;
        end
        // A dual pulse is carried as a store; the lost load still counts as an overflow.
        ovf_d = ovf_q | live_dual | (live_park & ~slot_free);

        own_io_d = own_io_q;
        op_we_d  = op_we_q;
        d_addr_d = d_addr_q;
        d_din_d  = d_din_q;
        if (grant_io) begin
            own_io_d = 1'b1;
            op_we_d  = io_we;
            d_addr_d = io_addr;
            d_din_d  = io_wdata;
        end else if (grant_cpu) begin
            own_io_d = 1'b0;
            op_we_d  = cand_we;
            d_addr_d = cand_addr;
            d_din_d  = cand_wdata;
        end

        starve_d = starve_q;
        if (grant_io) begin
            starve_d = '0;
        end else if (grant_cpu) begin
            if (!io_req) begin
                starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + 1'b1;
            end
        end else if (idle && !io_req) begin
            starve_d = '0;
        end

        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        if ((state_q == FIN) && !op_we_q) begin
            if (own_io_q) begin
                io_rdata_d = d_dout;
            end else begin
                cpu_rdata_d = d_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q   <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            own_io_q     <= 1'b0;
            op_we_q      <= 1'b0;
            starve_q     <= '0;
            ovf_q        <= 1'b0;
            d_addr_q     <= '0;
            d_din_q      <= '0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
        end else begin
            pend_vld_q   <= pend_vld_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            own_io_q     <= own_io_d;
            op_we_q      <= op_we_d;
            starve_q     <= starve_d;
            ovf_q        <= ovf_d;
            d_addr_q     <= d_addr_d;
            d_din_q      <= d_din_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rdata_q   <= io_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts each grant and its completion cycle;
// a negedge monitor compares every memory access, finish pulse, load datum and the overflow flag.
module tb_dmem_arbiter;

    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_l_valid = 1'b0;
    logic        cpu_s_valid = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_load_finish;
    logic        cpu_store_finish;
    logic [31:0] cpu_rdata;
    logic        io_req = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic [31:0] d_addr;
    logic [31:0] d_din;
    logic        wea;
    logic [31:0] d_dout;
    logic        cpu_ovf;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_l_valid(cpu_l_valid), .cpu_s_valid(cpu_s_valid),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_load_finish(cpu_load_finish), .cpu_store_finish(cpu_store_finish),
        .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .d_addr(d_addr), .d_din(d_din), .wea(wea), .d_dout(d_dout),
        .cpu_ovf(cpu_ovf)
    );

    typedef struct {
        bit          io;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          due;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        m_pend[$];
    logic [31:0] m_mem [64];
    logic [31:0] tb_mem [64];
    int          cyc = 0;
    int          m_busy = 0;
    int          m_starve = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_cpu_rd = '0;
    logic [31:0] m_io_rd = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cpu_fin_cnt = 0;
    int          io_ack_cnt = 0;
    int          io_ack_cyc = -1;
    int          cpu_at_ack = 0;
    bit          ack_last = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous-read memory: read data appears the cycle after the address.
    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (wea) tb_mem[d_addr[7:2]] <= d_din;
            d_dout <= tb_mem[d_addr[7:2]];
        end
    end

    task automatic issue(input txn_t t);
        t.rdata = m_mem[t.addr[7:2]];
        if (t.we) m_mem[t.addr[7:2]] = t.wdata;
        t.due = cyc + 1;
        exp_q.push_back(t);
        m_busy = 2;
    endtask

    task automatic park(input txn_t t);
        if (m_pend.size() == 0) m_pend.push_back(t);
        else m_ovf = 1'b1;
    endtask

    // Reference model: one access at a time, each occupying the granting edge plus two more.
    initial begin : model
        txn_t lreq, ioreq;
        bit   live, has_cpu;
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                m_pend.delete();
                m_busy = 0;
                m_starve = 0;
                m_ovf = 1'b0;
                m_cpu_rd = '0;
                m_io_rd = '0;
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc && !exp_q[0].we) begin
                    if (exp_q[0].io) m_io_rd = exp_q[0].rdata;
                    else m_cpu_rd = exp_q[0].rdata;
                end
                live = cpu_l_valid | cpu_s_valid;
                if (cpu_l_valid && cpu_s_valid) m_ovf = 1'b1;
                lreq = '{io: 1'b0, we: cpu_s_valid, addr: cpu_addr, wdata: cpu_wdata, rdata: '0, due: 0};
                ioreq = '{io: 1'b1, we: io_we, addr: io_addr, wdata: io_wdata, rdata: '0, due: 0};
                if (m_busy == 0) begin
                    has_cpu = (m_pend.size() > 0) || live;
                    if (io_req && (!has_cpu || m_starve == SM)) begin
                        issue(ioreq);
                        m_starve = 0;
                        if (live) park(lreq);
                    end else if (has_cpu) begin
                        if (m_pend.size() > 0) begin
                            issue(m_pend.pop_front());
                            if (live) park(lreq);
                        end else begin
                            issue(lreq);
                        end
                        m_starve = io_req ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
                    end else begin
                        m_starve = 0;
                    end
                end else begin
                    m_busy--;
                    if (live) park(lreq);
                end
            end
        end
    end

    initial begin : monitor
        txn_t e;
        int   nf;
        bit   acc;
        forever begin
            @(negedge clk);
            nf = int'(cpu_load_finish) + int'(cpu_store_finish) + int'(io_ack);
            chk("single_finish", 32'(nf <= 1), 32'd1);
            acc = (exp_q.size() > 0) && (exp_q[0].due == cyc + 1);
            if (acc) begin
                chk("wea", 32'(wea), 32'(exp_q[0].we));
                chk("d_addr", d_addr, exp_q[0].addr);
                if (exp_q[0].we) chk("d_din", d_din, exp_q[0].wdata);
            end else begin
                chk("wea_idle", 32'(wea), 32'd0);
            end
            if (nf != 0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_finish: got ld=%0b st=%0b ack=%0b expected none (cycle %0d)",
                             cpu_load_finish, cpu_store_finish, io_ack, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("finish_cycle", 32'(cyc), 32'(e.due));
                    chk("finish_kind", {29'd0, io_ack, cpu_store_finish, cpu_load_finish},
                        e.io ? 32'd4 : (e.we ? 32'd2 : 32'd1));
                    if (!e.we) chk("load_data", e.io ? io_rdata : cpu_rdata, e.rdata);
                end
                if (cpu_load_finish || cpu_store_finish) cpu_fin_cnt++;
                if (io_ack) begin
                    io_ack_cnt++;
                    io_ack_cyc = cyc;
                    cpu_at_ack = cpu_fin_cnt;
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missing_finish: got no pulse expected io=%0b we=%0b at cycle %0d", e.io, e.we, e.due);
            end
            chk("cpu_rdata", cpu_rdata, m_cpu_rd);
            chk("io_rdata", io_rdata, m_io_rd);
            chk("cpu_ovf", 32'(cpu_ovf), 32'(m_ovf));
        end
    end

    // Pulses last exactly one sampling edge; ack_last reports io_ack of the cycle just ended.
    task automatic tick();
        @(negedge clk);
        ack_last = io_ack;
        @(posedge clk);
        #1;
        cpu_l_valid = 1'b0;
        cpu_s_valid = 1'b0;
    endtask

    task automatic rand_io();
        io_we = ($urandom_range(0, 1) == 1);
        io_addr = 32'($urandom_range(0, 63)) << 2;
        io_wdata = $urandom;
    endtask

    initial begin : stim
        int t0, c0, a0, r;
        repeat (3) tick();
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_finish", {29'd0, io_ack, cpu_store_finish, cpu_load_finish}, 32'd0);
        chk("rst_d_addr", d_addr, 32'd0);
        chk("rst_d_din", d_din, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_io_rdata", io_rdata, 32'd0);
        chk("rst_ovf", 32'(cpu_ovf), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        cpu_l_valid = 1'b1; cpu_addr = 32'h10;
        tick();
        chk("ld_acc_addr", d_addr, 32'h10);
        chk("ld_acc_wea", 32'(wea), 32'd0);
        tick();
        chk("ld_finish", 32'(cpu_load_finish), 32'd1);
        chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        cpu_s_valid = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
        tick();
        chk("st_acc_wea", 32'(wea), 32'd1);
        chk("st_acc_din", d_din, 32'h1234_5678);
        tick();
        chk("st_fin_wea", 32'(wea), 32'd0);
        chk("st_finish", 32'(cpu_store_finish), 32'd1);
        tick();
        cpu_l_valid = 1'b1; cpu_addr = 32'h20;
        tick();
        tick();
        chk("st_readback", cpu_rdata, 32'h1234_5678);
        tick();

        // CPU wins the tie; the IO access follows the 3-cycle CPU access and acks 4 cycles after the grant edge.
        a0 = io_ack_cnt;
        io_req = 1'b1; io_we = 1'b0; io_addr = 32'h30;
        cpu_l_valid = 1'b1; cpu_addr = 32'h40;
        t0 = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_last) break;
        end
        io_req = 1'b0;
        chk("tie_io_acks", 32'(io_ack_cnt - a0), 32'd1);
        chk("tie_io_ack_cycle", 32'(io_ack_cyc), 32'(t0 + 4));
        repeat (3) tick();

        c0 = cpu_fin_cnt; a0 = io_ack_cnt;
        io_req = 1'b1; io_we = 1'b1; io_addr = 32'h50; io_wdata = 32'hCAFE_0050;
        for (int k = 0; k < 45; k++) begin
            if (k % 3 == 0 && k < 36) begin
                cpu_l_valid = 1'b1;
                cpu_addr = 32'h80 + 32'((k / 3) * 4);
            end
            tick();
            if (ack_last) io_req = 1'b0;
        end
        chk("starve_cpu_before_io", 32'(cpu_at_ack - c0), 32'd8);
        chk("starve_cpu_total", 32'(cpu_fin_cnt - c0), 32'd12);
        chk("starve_io_acks", 32'(io_ack_cnt - a0), 32'd1);
        chk("starve_no_ovf", 32'(cpu_ovf), 32'd0);
        repeat (3) tick();

        c0 = cpu_fin_cnt;
        cpu_l_valid = 1'b1; cpu_addr = 32'h14;
        tick();
        cpu_l_valid = 1'b1; cpu_addr = 32'h18;
        tick();
        cpu_s_valid = 1'b1; cpu_addr = 32'h1C; cpu_wdata = 32'h0000_1C1C;
        tick();
        chk("ovf_set", 32'(cpu_ovf), 32'd1);
        repeat (10) tick();
        chk("ovf_sticky", 32'(cpu_ovf), 32'd1);
        chk("ovf_served", 32'(cpu_fin_cnt - c0), 32'd2);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", 32'(cpu_ovf), 32'd0);
        tick();
        c0 = cpu_fin_cnt;
        cpu_s_valid = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'h0BAD_F00D;
        tick();
        chk("abort_acc_wea", 32'(wea), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wea", 32'(wea), 32'd0);
        chk("abort_finish", 32'(cpu_store_finish), 32'd0);
        chk("abort_d_addr", d_addr, 32'd0);
        chk("abort_d_din", d_din, 32'd0);
        repeat (4) tick();
        chk("abort_no_late_finish", 32'(cpu_fin_cnt - c0), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            cpu_addr = 32'($urandom_range(0, 63)) << 2;
            cpu_wdata = $urandom;
            if (r < 25) cpu_l_valid = 1'b1;
            else if (r < 40) cpu_s_valid = 1'b1;
            else if (r < 42) begin
                cpu_l_valid = 1'b1;
                cpu_s_valid = 1'b1;
            end
            if (ack_last) begin
                io_req = ($urandom_range(0, 1) == 1);
                rand_io();
            end else if (!io_req && $urandom_range(0, 7) == 0) begin
                io_req = 1'b1;
                rand_io();
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ack_last) io_req = 1'b0;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
